sb_spram256ka: RTL and testbench
================================

Name: sb_spram256ka

Overview:
- Behavioural single-port RAM of 16384 words x 16 bits with nibble write masks and power-management controls.
- Used as a storage primitive behind the memory subsystem. The memory controller pairs two instances side by side to form 32-bit words.
- All accesses are synchronous to clk. Read data appears on the cycle after the address is presented.

Parameters:
- ADDR_WIDTH, 14, address width; depth is 2^ADDR_WIDTH words, 16384 by default.
- DATA_WIDTH, 16, word width. Fixed at 16, because the write mask has one bit per 4-bit nibble.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_WIDTH  word address for reads and writes.
- datain  input  16  write data.
- maskwren  input  4  per-nibble write enable. bit0 selects [3:0], bit1 [7:4], bit2 [11:8], bit3 [15:12].
- wren  input  1  1 = write cycle, 0 = read cycle.
- chipselect  input  1  1 = access enabled.
- standby  input  1  1 = standby: no access, contents and output retained.
- sleep  input  1  1 = sleep: no access, contents retained, output forced to 0.
- poweroff  input  1  active-low power-off. 0 = powered down; 1 = normal operation.
- dataout  output  16  registered read data.

Behaviour:
- Storage: 2^ADDR_WIDTH x 16 array, all locations 0 at time zero. reset does not clear the array.
- Each rising edge of clk evaluates the following conditions in priority order; the first one that holds applies:
  - reset=1: dataout <= 0. No write. Array unchanged.
  - poweroff=0: dataout <= 0. All array locations cleared to 0, modelling loss of contents. No access.
  - sleep=1: dataout <= 0. No access. Array retained.
  - standby=1: dataout holds. No access.
  - chipselect=0: dataout holds. No access.
  - wren=1 (write cycle):
    - For each nibble i with maskwren[i]=1, write datain nibble i into array[address] nibble i.
    - Nibbles with maskwren[i]=0 keep their old value.
    - dataout holds its previous value; there is no write-through.
    - maskwren=0000 with wren=1 is a no-op write; dataout still holds.
  - wren=0 (read cycle): dataout <= array[address], with the value as stored before this edge. Read latency is one clock.
- dataout reset value: 0.
- Back-to-back operations:
  - A read on the cycle after a write to the same address returns the newly written data.
  - Consecutive reads pipeline at one word per clock.
- Address range: every address value is in range; there is no wrap or aliasing logic. The full 14-bit address selects the word.
- Narrower address drivers (for example 13 bits) are zero-extended by the instantiator. The block needs no special handling for them.
- Reset asserted in the same cycle as a write: the write is suppressed.
- Inputs are sampled only at the clock edge. There is no combinational path from inputs to dataout.

Test Plan:
- Reset check: pulse reset=1 for 2 cycles with wren=1, address=0x0005, datain=0xFFFF, maskwren=1111. Then read 0x0005 -> dataout=0 after reset; the read returns 0x0000, proving the write was suppressed.
- Full write/read: write 0xA5C3 to 0x1234 with maskwren=1111, then read 0x1234. Required: dataout=0xA5C3 one cycle after the read; dataout unchanged during the write cycle.
- Nibble mask: with 0x1234 holding 0xA5C3, write 0x0FF0 with maskwren=0110, then read. Required: dataout=0xAFF3.
- Pipelined reads: write 0x1111 to 0x0000 and 0x2222 to 0x3FFF. Issue reads of 0x0000 and 0x3FFF on consecutive cycles. Required: 0x1111, then 0x2222 on the following cycle.
- Power states, with 0x0010 holding 0xBEEF:
  - chipselect=0 or standby=1 -> dataout holds and a write attempt leaves the data intact.
  - sleep=1 -> dataout=0, then a read after sleep=0 returns 0xBEEF.
  - poweroff=0 for one cycle -> a subsequent read returns 0x0000.
- Write-then-read same address: write 0x7E7E to 0x0100, read 0x0100 on the next cycle -> dataout=0x7E7E.

Source files
------------

// File: rtl/sb_spram256ka.sv
// Single-port 16-bit-wide RAM with per-nibble write enables, registered read,
// and standby / sleep / power-off controls.
module sb_spram256ka #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   datain,
    input  logic [DATA_WIDTH/4-1:0] maskwren,
    input  logic                    wren,
    input  logic                    chipselect,
    input  logic                    standby,
    input  logic                    sleep,
    input  logic                    poweroff,
    output logic [DATA_WIDTH-1:0]   dataout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 4;

    logic clear_all;
    logic zero_out;
    logic wr_en;
    logic rd_en;

    // Priority: reset > power-off > sleep > standby > chip-select > read/write.
    always_comb begin
        clear_all = 1'b0;
        zero_out  = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        if (reset) begin
            zero_out = 1'b1;
        end else if (!poweroff) begin
            zero_out  = 1'b1;
            clear_all = 1'b1;
        end else if (sleep) begin
            zero_out = 1'b1;
        end else if (!standby && chipselect) begin
            wr_en = wren;
            rd_en = !wren;
        end
    end

    // One independent nibble-wide memory per write-mask bit.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [3:0] mem [DEPTH];
            logic [3:0] dout_q;

            always_ff @(posedge clk) begin
                if (clear_all) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        mem[ADDR_WIDTH'(j)] <= '0;
                    end
                end else if (wr_en && maskwren[gi]) begin
                    mem[address] <= datain[gi*4 +: 4];
                end
            end

            // Read returns the pre-edge contents; writes leave the output untouched.
            always_ff @(posedge clk) begin
                if (zero_out) begin
                    dout_q <= '0;
                end else if (rd_en) begin
                    dout_q <= mem[address];
                end
            end

            assign dataout[gi*4 +: 4] = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sb_spram256ka.sv
// Self-checking bench for sb_spram256ka: directed scenarios followed by random
// traffic, all compared against a behavioural array model.
module tb_sb_spram256ka;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] address;
    logic [15:0] datain;
    logic [3:0]  maskwren;
    logic        wren;
    logic        chipselect;
    logic        standby;
    logic        sleep;
    logic        poweroff;
    logic [15:0] dataout;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [16384];
    logic [15:0] model_dout = 16'h0000;

    always #5 clk = ~clk;

    sb_spram256ka #(.ADDR_WIDTH(14), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .datain     (datain),
        .maskwren   (maskwren),
        .wren       (wren),
        .chipselect (chipselect),
        .standby    (standby),
        .sleep      (sleep),
        .poweroff   (poweroff),
        .dataout    (dataout)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s dataout=%h", tag, got);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the documented rules,
    // then compare the DUT output just after the edge.
    task automatic cycle(input string tag, input logic rst, input logic pwr,
                         input logic slp, input logic stb, input logic cs,
                         input logic we, input logic [3:0] msk,
                         input logic [13:0] a, input logic [15:0] d);
        reset = rst; poweroff = pwr; sleep = slp; standby = stb;
        chipselect = cs; wren = we; maskwren = msk; address = a; datain = d;
        @(posedge clk);
        if (rst) begin
            model_dout = 16'h0000;
        end else if (!pwr) begin
            for (int j = 0; j < 16384; j++) model_mem[j] = 16'h0000;
            model_dout = 16'h0000;
        end else if (slp) begin
            model_dout = 16'h0000;
        end else if (stb || !cs) begin
            // output and array retained
        end else if (we) begin
            for (int n = 0; n < 4; n++)
                if (msk[n]) model_mem[a][n*4 +: 4] = d[n*4 +: 4];
        end else begin
            model_dout = model_mem[a];
        end
        #1;
        check(tag, dataout, model_dout);
    endtask

    task automatic wr(input string tag, input logic [13:0] a, input logic [15:0] d,
                      input logic [3:0] msk);
        cycle(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, msk, a, d);
    endtask

    task automatic rd(input string tag, input logic [13:0] a);
        cycle(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, a, 16'h0000);
    endtask

    initial begin
        for (int j = 0; j < 16384; j++) model_mem[j] = 16'h0000;
        reset = 1'b0; poweroff = 1'b1; sleep = 1'b0; standby = 1'b0;
        chipselect = 1'b0; wren = 1'b0; maskwren = 4'h0; address = '0; datain = '0;
        #2;

        // Establish a known all-zero array, then reset while attempting a write.
        cycle("init_pwroff", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 14'h0, 16'h0);
        cycle("rst_wr0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 14'h0005, 16'hFFFF);
        check("rst_dout0", dataout, 16'h0000);
        cycle("rst_wr1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 14'h0005, 16'hFFFF);
        rd("rst_rd", 14'h0005);
        check("rst_wr_suppressed", dataout, 16'h0000);

        wr("full_wr", 14'h1234, 16'hA5C3, 4'hF);
        check("full_wr_hold", dataout, 16'h0000);
        rd("full_rd", 14'h1234);
        check("full_rd_val", dataout, 16'hA5C3);

        wr("mask_wr", 14'h1234, 16'h0FF0, 4'b0110);
        check("mask_wr_hold", dataout, 16'hA5C3);
        rd("mask_rd", 14'h1234);
        check("mask_rd_val", dataout, 16'hAFF3);

        wr("pipe_wr0", 14'h0000, 16'h1111, 4'hF);
        wr("pipe_wr1", 14'h3FFF, 16'h2222, 4'hF);
        rd("pipe_rd0", 14'h0000);
        check("pipe_rd0_val", dataout, 16'h1111);
        rd("pipe_rd1", 14'h3FFF);
        check("pipe_rd1_val", dataout, 16'h2222);

        wr("pwr_wr", 14'h0010, 16'hBEEF, 4'hF);
        rd("pwr_rd", 14'h0010);
        check("pwr_rd_val", dataout, 16'hBEEF);
        cycle("cs0_wr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 14'h0010, 16'h0000);
        check("cs0_hold", dataout, 16'hBEEF);
        cycle("stby_wr", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 14'h0010, 16'h0000);
        check("stby_hold", dataout, 16'hBEEF);
        cycle("stby_rd", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 14'h1234, 16'h0000);
        check("stby_rd_hold", dataout, 16'hBEEF);
        rd("intact_rd", 14'h0010);
        check("intact_val", dataout, 16'hBEEF);
        cycle("sleep", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 14'h0010, 16'h0000);
        check("sleep_zero", dataout, 16'h0000);
        rd("wake_rd", 14'h0010);
        check("wake_val", dataout, 16'hBEEF);
        cycle("pwroff", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 14'h0010, 16'h0000);
        check("pwroff_zero", dataout, 16'h0000);
        rd("pwron_rd", 14'h0010);
        check("pwron_cleared", dataout, 16'h0000);

        wr("wr_rd_wr", 14'h0100, 16'h7E7E, 4'hF);
        rd("wr_rd_rd", 14'h0100);
        check("wr_rd_val", dataout, 16'h7E7E);

        // Random traffic concentrated on a few addresses so reads hit earlier writes.
        for (int i = 0; i < 1500; i++) begin
            logic [13:0] a;
            logic rst, pwr, slp, stb, cs, we;
            a   = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 7));
            rst = ($urandom_range(0, 49) == 0);
            pwr = ($urandom_range(0, 149) != 0);
            slp = ($urandom_range(0, 19) == 0);
            stb = ($urandom_range(0, 19) == 0);
            cs  = ($urandom_range(0, 9) != 0);
            we  = $urandom_range(0, 1) == 1;
            cycle("rand", rst, pwr, slp, stb, cs, we, 4'($urandom), a, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
